data_sram_resp: RTL



---
 rtl/data_sram_resp.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// Data-side word SRAM responder for the MEM stage: byte-lane stores, full-word loads, programmable wait states.
// Latency: accept at cycle T -> data_ok at T+1+WAIT_CYC; stores commit on the edge that ends the response cycle.
// Backpressure: addr_ok only in IDLE/RESP; the requester holds req and its payload through WAIT.
module data_sram_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [3:0] WAIT_INIT = WAIT_CYC[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;

    logic                accept;
    logic                legal;
    logic                commit;
    logic                rd_load;
    logic                fwd;
    logic [ADDR_W-1:0]   rd_idx;
    logic [ADDR_W-1:0]   wr_idx;
    logic [31:0]         rd_word;
    logic                unused_addr_bits;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (accept) begin
                    state_nxt = (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        addr_ok = resetn & req & ((state_q == S_IDLE) | (state_q == S_RESP));
        data_ok = resetn & (state_q == S_RESP);
        err     = resetn & (state_q == S_RESP) & ~legal;
    end

    assign accept = addr_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= WAIT_INIT;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr[ADDR_W+1:0];
            wstrb_q <= wstrb;
            wdata_q <= wdata;
        end
    end

    // Legality of the latched request; loads only check size and alignment
    always_comb begin
        legal = 1'b0;
        case (size_q)
            2'd0:    legal = !wr_q || (wstrb_q == (4'b0001 << addr_q[1:0]));
            2'd1:    legal = !addr_q[0] && (!wr_q || (wstrb_q == (4'b0011 << addr_q[1:0])));
            2'd2:    legal = (addr_q[1:0] == 2'd0) && (!wr_q || (wstrb_q == 4'b1111));
            default: legal = 1'b0;
        endcase
    end

    assign wr_idx  = addr_q[ADDR_W+1:2];
    assign commit  = resetn && (state_q == S_RESP) && wr_q && legal;
    assign rd_load = (accept && (WAIT_INIT == 4'd0)) || ((state_q == S_WAIT) && (cnt_q <= 4'd1));
    assign rd_idx  = accept ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    assign fwd     = commit && (wr_idx == rd_idx);

    // A store committing on the same edge bypasses the array for its enabled lanes
    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (fwd && wstrb_q[b]) begin
                rd_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= 32'd0;
        end else if (rd_load) begin
            rdata <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
